if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/if_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch unit shared types and default constants
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned FETCH_PC_STEP  = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, instr} skid buffer behind the fetch output register
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] in_pc,
    input  logic [N-1:0] in_instr,
    output logic         valid,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_instr
);

    // Occupancy: clear wins, a push (even alongside a pop) refills the slot
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Payload captured on every push
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pc    <= '0;
            out_instr <= '0;
        end else if (push) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch with redirect, output register and skid (FETCH_PERF_CNT_EN adds counters)
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(FETCH_RESET_PC),
    parameter int unsigned  PC_STEP  = FETCH_PC_STEP
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         jmp_valid,
    input  logic [N-1:0] jmp_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count
`endif
);

    fetch_state_t state, state_nxt;

    logic [N-1:0] pc;
    logic         pending;
    logic [N-1:0] pend_pc;

    logic         oreg_valid;
    logic [N-1:0] oreg_pc;
    logic [N-1:0] oreg_instr;

    logic         skid_valid;
    logic [N-1:0] skid_pc;
    logic [N-1:0] skid_instr;
    logic         skid_push;
    logic         skid_pop;

    logic         fire;

    assign imem_addr = pc;
    assign fire      = out_valid & out_ready;

    // Presented entry: output register first, otherwise the arriving response flows straight through
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (!reset) begin
            if (oreg_valid) begin
                out_valid = 1'b1;
                out_pc    = oreg_pc;
                out_instr = oreg_instr;
            end else if (pending) begin
                out_valid = 1'b1;
                out_pc    = pend_pc;
                out_instr = imem_rdata;
            end
        end
    end

    // Next state, request strobe and skid control
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        skid_pop  = fire & skid_valid;
        skid_push = pending & oreg_valid & (~fire | skid_valid);
        case (state)
            FETCH: begin
                imem_req = ~((out_valid & ~out_ready & pending) | skid_valid);
                if (skid_push && !skid_pop) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (fire) begin
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                imem_req  = 1'b1;
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = FLUSH;
            end
        endcase
        if (jmp_valid) begin
            imem_req  = 1'b0;
            state_nxt = FLUSH;
        end
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    // State, PC and in-flight request tracking; a redirect drops the outstanding response
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FLUSH;
            pc      <= RESET_PC;
            pending <= 1'b0;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (jmp_valid) begin
                pc      <= jmp_pc;
                pending <= 1'b0;
            end else begin
                pending <= imem_req;
                if (imem_req) begin
                    pc      <= pc + N'(PC_STEP);
                    pend_pc <= pc;
                end
            end
        end
    end

    // Output register: refilled from the skid (older) before the live response
    always_ff @(posedge clk) begin
        if (reset) begin
            oreg_valid <= 1'b0;
            oreg_pc    <= '0;
            oreg_instr <= '0;
        end else if (jmp_valid) begin
            oreg_valid <= 1'b0;
        end else if (oreg_valid) begin
            if (fire) begin
                if (skid_valid) begin
                    oreg_pc    <= skid_pc;
                    oreg_instr <= skid_instr;
                end else if (pending) begin
                    oreg_pc    <= pend_pc;
                    oreg_instr <= imem_rdata;
                end else begin
                    oreg_valid <= 1'b0;
                end
            end
        end else if (pending && !fire) begin
            oreg_valid <= 1'b1;
            oreg_pc    <= pend_pc;
            oreg_instr <= imem_rdata;
        end
    end

    fetch_skid_buf #(
        .N(N)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (jmp_valid),
        .push      (skid_push),
        .pop       (skid_pop),
        .in_pc     (pend_pc),
        .in_instr  (imem_rdata),
        .valid     (skid_valid),
        .out_pc    (skid_pc),
        .out_instr (skid_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    // Transfer and back-pressure counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fire) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
